// File: rtl/uart_pkg.sv
// Shared UART types and constants: receive FSM states, data-bit encodings and IRQ event indices.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  localparam logic [1:0] UART_DBITS_5 = 2'd0;
  localparam logic [1:0] UART_DBITS_6 = 2'd1;
  localparam logic [1:0] UART_DBITS_7 = 2'd2;
  localparam logic [1:0] UART_DBITS_8 = 2'd3;

  localparam int IRQ_RX_DONE         = 0;
  localparam int IRQ_UART_PARITY_ERR = 1;
  localparam int IRQ_UART_BAD_FRAME  = 2;
  localparam int IRQ_UART_OVERRUN    = 3;

  function automatic int unsigned data_bits_num(input logic [1:0] enc);
    return 32'd5 + 32'(enc);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..max(div,1)-1, ticks on the last count, reload re-phases to 0.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 reload_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] max_m1;

  // A divider of 0 behaves like 1, i.e. one tick per clock.
  assign max_m1 = (div_i == '0) ? '0 : div_i - DIV_WIDTH'(1);
  assign tick_o = (cnt == max_m1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (reload_i || cnt >= max_m1) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled LSB-first deserializer with a one-entry holding register and event pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  rx_i,
  input  logic                  rx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic [1:0]            data_bits_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  rx_busy_o,
  output logic                  rx_done_o,
  output logic                  parity_err_o,
  output logic                  bad_frame_o,
  output logic                  overrun_o,
  output uart_rx_state_t        state_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] MID_T  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);

  uart_rx_state_t state, state_nx;

  logic                  rx_q1, rx_s, rx_s_d;
  logic                  tick, start_det, bit_end;
  logic [TW-1:0]         tick_cnt;
  logic [IW-1:0]         bit_idx, last_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_flag;
  logic [1:0]            cfg_bits;
  logic                  cfg_par_en, cfg_par_odd, cfg_stop2;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  load_cfg, take_data, take_par, stop_first, deliver, frame_err;

  assign start_det = rx_en_i && rx_s_d && !rx_s;
  assign bit_end   = tick && (tick_cnt == ((state == RX_START) ? MID_T : LAST_T));
  assign last_idx  = IW'(data_bits_num(cfg_bits) - 1);
  assign rx_busy_o = (state != RX_IDLE);
  assign state_o   = state;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .div_i    ((state == RX_IDLE) ? baud_div_i : div_q),
    .reload_i (load_cfg),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= RX_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_cfg   = 1'b0;
    take_data  = 1'b0;
    take_par   = 1'b0;
    stop_first = 1'b0;
    deliver    = 1'b0;
    frame_err  = 1'b0;
    if (state != RX_IDLE && !rx_en_i) begin
      state_nx = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE: if (start_det) begin
          load_cfg = 1'b1;
          state_nx = RX_START;
        end
        RX_START: if (bit_end) state_nx = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA: if (bit_end) begin
          take_data = 1'b1;
          if (bit_idx == last_idx) state_nx = cfg_par_en ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (bit_end) begin
          take_par = 1'b1;
          state_nx = RX_STOP;
        end
        RX_STOP: if (bit_end) begin
          if (!rx_s) begin
            frame_err = 1'b1;
            state_nx  = RX_WAIT_IDLE;
          end else if (cfg_stop2 && !stop_idx) begin
            stop_first = 1'b1;
          end else begin
            deliver  = 1'b1;
            state_nx = RX_IDLE;
          end
        end
        RX_WAIT_IDLE: if (rx_s) state_nx = RX_IDLE;
        default: state_nx = RX_IDLE;
      endcase
    end
  end

  // Holding register: a byte moves upstream on any cycle with data_valid_o & data_ready_i;
  // a new byte may be loaded in that same cycle, otherwise a delivery into a full register overruns.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_q1 <= 1'b1;  rx_s <= 1'b1;  rx_s_d <= 1'b1;
      tick_cnt <= '0;  bit_idx <= '0;  stop_idx <= 1'b0;
      shreg <= '0;  par_flag <= 1'b0;
      cfg_bits <= UART_DBITS_8;  cfg_par_en <= 1'b0;  cfg_par_odd <= 1'b0;  cfg_stop2 <= 1'b0;
      div_q <= '0;
      data_o <= '0;  data_valid_o <= 1'b0;
      rx_done_o <= 1'b0;  parity_err_o <= 1'b0;  bad_frame_o <= 1'b0;  overrun_o <= 1'b0;
    end else begin
      rx_q1  <= rx_i;
      rx_s   <= rx_q1;
      rx_s_d <= rx_s;
      rx_done_o    <= 1'b0;
      parity_err_o <= 1'b0;
      bad_frame_o  <= frame_err;
      overrun_o    <= 1'b0;

      if (state == RX_IDLE)  tick_cnt <= '0;
      else if (bit_end)      tick_cnt <= '0;
      else if (tick)         tick_cnt <= tick_cnt + TW'(1);

      if (load_cfg) begin
        cfg_bits <= data_bits_i;  cfg_par_en <= parity_en_i;
        cfg_par_odd <= parity_odd_i;  cfg_stop2 <= stop2_i;
        div_q <= baud_div_i;
        shreg <= '0;  par_flag <= 1'b0;  bit_idx <= '0;  stop_idx <= 1'b0;
      end
      if (take_data) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + IW'(1);
      end
      if (take_par)   par_flag <= (rx_s != ((^shreg) ^ cfg_par_odd));
      if (stop_first) stop_idx <= 1'b1;

      if (deliver) begin
        parity_err_o <= par_flag;
        if (!data_valid_o || data_ready_i) begin
          data_o       <= shreg;
          data_valid_o <= 1'b1;
          rx_done_o    <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 64 clk per bit (oversample 16, divider 4), frames driven bit by bit.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int BIT = 64;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           rx = 1'b1;
  logic           rx_en = 1'b1;
  logic [15:0]    baud_div = 16'd4;
  logic [1:0]     data_bits = 2'd3;
  logic           parity_en = 1'b0;
  logic           parity_odd = 1'b0;
  logic           stop2 = 1'b0;
  logic [7:0]     data;
  logic           data_valid;
  logic           data_ready = 1'b1;
  logic           rx_busy, rx_done, parity_err, bad_frame, overrun;
  uart_rx_state_t state;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int n_done, n_perr, n_both, n_bad, n_ovr, done_cyc;
  logic [7:0] done_data;
  logic       done_valid;

  uart_rx_core dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .rx_i         (rx),
    .rx_en_i      (rx_en),
    .baud_div_i   (baud_div),
    .data_bits_i  (data_bits),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
    .data_o       (data),
    .data_valid_o (data_valid),
    .data_ready_i (data_ready),
    .rx_busy_o    (rx_busy),
    .rx_done_o    (rx_done),
    .parity_err_o (parity_err),
    .bad_frame_o  (bad_frame),
    .overrun_o    (overrun),
    .state_o      (state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_done) begin
      n_done++;  done_cyc = cyc;  done_data = data;  done_valid = data_valid;
    end
    if (parity_err) begin
      n_perr++;
      if (rx_done) n_both++;
    end
    if (bad_frame) n_bad++;
    if (overrun)   n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_done = 0;  n_perr = 0;  n_both = 0;  n_bad = 0;  n_ovr = 0;
    done_cyc = -1;  done_data = 8'h00;  done_valid = 1'b0;
  endtask

  // drive the line for n cycles; callers stay aligned to posedge+1
  task automatic line(input logic b, input int n);
    rx = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                            input int nstop, input logic stop_val);
    edge_cyc = cyc;
    line(1'b0, BIT);
    for (int i = 0; i < nb; i++) line(d[i], BIT);
    if (par >= 0) line(par[0], BIT);
    for (int i = 0; i < nstop; i++) line(stop_val, BIT);
  endtask

  initial begin
    clr();
    #23;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    chk("rst_done", 32'(rx_done), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_bad", 32'(bad_frame), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    line(1'b1, 8);

    // 8N1 0xA5, latency edge + 608 + 3
    clr();
    send_frame(8'hA5, 8, -1, 1, 1'b1);
    line(1'b1, 16);
    chk("a5_done_cnt", 32'(n_done), 32'd1);
    chk("a5_latency", 32'(done_cyc - edge_cyc), 32'd611);
    chk("a5_data", 32'(done_data), 32'hA5);
    chk("a5_valid", 32'(done_valid), 32'h1);
    chk("a5_err", 32'(n_perr + n_bad + n_ovr), 32'd0);
    chk("a5_idle", 32'(rx_busy), 32'h0);

    // 8E1 0x3C: four ones, so a parity bit of 1 is wrong and 0 is right
    parity_en = 1'b1;
    clr();
    send_frame(8'h3C, 8, 1, 1, 1'b1);
    line(1'b1, 16);
    chk("par_bad_done", 32'(n_done), 32'd1);
    chk("par_bad_data", 32'(done_data), 32'h3C);
    chk("par_bad_perr", 32'(n_perr), 32'd1);
    chk("par_bad_same_cycle", 32'(n_both), 32'd1);
    clr();
    send_frame(8'h3C, 8, 0, 1, 1'b1);
    line(1'b1, 16);
    chk("par_ok_done", 32'(n_done), 32'd1);
    chk("par_ok_perr", 32'(n_perr), 32'd0);
    parity_en = 1'b0;

    // 0x55 with a zero stop bit, then break held low
    clr();
    send_frame(8'h55, 8, -1, 1, 1'b0);
    line(1'b0, 20 * BIT);
    chk("brk_bad", 32'(n_bad), 32'd1);
    chk("brk_done", 32'(n_done), 32'd0);
    chk("brk_valid", 32'(data_valid), 32'h0);
    chk("brk_busy", 32'(rx_busy), 32'h1);
    line(1'b1, 16);
    chk("brk_release", 32'(rx_busy), 32'h0);
    clr();
    send_frame(8'h12, 8, -1, 1, 1'b1);
    line(1'b1, 16);
    chk("after_brk_data", 32'(done_data), 32'h12);
    chk("after_brk_done", 32'(n_done), 32'd1);

    // 24-cycle low glitch is shorter than half a bit
    clr();
    line(1'b0, 24);
    line(1'b1, 2 * BIT);
    chk("glitch_done", 32'(n_done), 32'd0);
    chk("glitch_evt", 32'(n_perr + n_bad + n_ovr), 32'd0);
    chk("glitch_busy", 32'(rx_busy), 32'h0);
    chk("glitch_valid", 32'(data_valid), 32'h0);

    // overrun with upstream stalled
    data_ready = 1'b0;
    clr();
    send_frame(8'h11, 8, -1, 1, 1'b1);
    line(1'b1, 16);
    chk("ovr_first_data", 32'(data), 32'h11);
    chk("ovr_first_valid", 32'(data_valid), 32'h1);
    send_frame(8'h22, 8, -1, 1, 1'b1);
    line(1'b1, 16);
    chk("ovr_pulse", 32'(n_ovr), 32'd1);
    chk("ovr_done_cnt", 32'(n_done), 32'd1);
    chk("ovr_kept_data", 32'(data), 32'h11);
    data_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_hold", 32'(data_valid), 32'h1);
    @(negedge clk);
    chk("ovr_valid_drop", 32'(data_valid), 32'h0);
    @(posedge clk);
    #1;

    // reset in the middle of the data bits of 0x7E
    clr();
    line(1'b0, BIT);
    line(1'b0, BIT);
    line(1'b1, BIT);
    line(1'b1, BIT / 2);
    chk("mid_busy_before", 32'(rx_busy), 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data), 32'h0);
    chk("mid_rst_busy", 32'(rx_busy), 32'h0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_state", 32'(state), 32'(RX_IDLE));
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b1;
    line(1'b1, BIT);
    clr();
    send_frame(8'h81, 8, -1, 1, 1'b1);
    line(1'b1, 16);
    chk("post_rst_data", 32'(done_data), 32'h81);
    chk("post_rst_done", 32'(n_done), 32'd1);

    // 7N2: only bits 0..6 of 0x81 are sent
    data_bits = 2'd2;
    stop2 = 1'b1;
    clr();
    send_frame(8'h81, 7, -1, 2, 1'b1);
    line(1'b1, 16);
    chk("7n2_data", 32'(done_data), 32'h01);
    chk("7n2_done", 32'(n_done), 32'd1);
    chk("7n2_bad", 32'(n_bad), 32'd0);
    chk("7n2_latency", 32'(done_cyc - edge_cyc), 32'd611);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive engine of the UART. It oversamples the rx line, deserializes LSB-first frames (start, 5..8 data bits, optional parity, 1 or 2 stop bits) and presents each byte through a one-entry valid/ready holding register to the upstream FIFO. It generates per-frame event pulses (rx_done, parity error, bad frame, overrun) for the IRQ_EVENT logic and the rx_status bit of STATS.

Parameters:
OVERSAMPLE, 16, baud ticks per bit; even, >=8
DATA_WIDTH, 8, holding register width; equals UFIFO_WIDTH
DIV_WIDTH, 16, width of the baud divider input

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
rx_i  in  1  serial line, asynchronous, idle high
rx_en_i  in  1  receiver enable
baud_div_i  in  DIV_WIDTH  clk cycles per oversample tick; 0 is treated as 1
data_bits_i  in  2  0..3 -> 5..8 data bits
parity_en_i  in  1  parity bit present
parity_odd_i  in  1  1 = odd parity, 0 = even parity
stop2_i  in  1  two stop bits
data_o  out  DATA_WIDTH  received byte, zero-extended above data_bits
data_valid_o  out  1  holding register full
data_ready_i  in  1  upstream FIFO accepts (push when valid & ready)
rx_busy_o  out  1  state != IDLE (STATS.rx_status)
rx_done_o  out  1  1-cycle pulse, frame delivered
parity_err_o  out  1  1-cycle pulse
bad_frame_o  out  1  1-cycle pulse
overrun_o  out  1  1-cycle pulse

Behaviour:
- Reset: all outputs 0, data_o 0; synchronizer flops 1; state IDLE; counters 0.
- rx_i passes through a 2-flop synchronizer. All sampling uses the synchronized value rx_s.
- Tick generator: a counter runs 0..max(baud_div_i,1)-1. A tick is asserted in the cycle where count == max-1. On the start-edge detect the counter reloads 0, so the phase aligns to the edge.
- Config inputs are sampled at start detect and held for the whole frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: when rx_en_i=1 and rx_s falls 1->0, go to START and clear the tick-in-bit counter.
  - START: at tick OVERSAMPLE/2-1 (mid-bit), sample rx_s. If 0, go to DATA. If 1 (glitch), return to IDLE with no pulse.
  - DATA: sample every OVERSAMPLE ticks, shifting LSB first. After the configured bit count, go to PARITY if parity_en, else STOP.
  - PARITY: sample one bit. Mismatch with the computed parity latches a parity-error flag.
  - STOP: sample at each stop-bit mid-point (1 or 2).
    - Any 0 sampled: pulse bad_frame_o, drop the data, go to WAIT_IDLE.
    - All 1 at the final stop mid-point: deliver and return to IDLE.
  - WAIT_IDLE: stay until rx_s == 1 (break handling), then go to IDLE.
- Deliver (cycle after the final stop sample, registered):
  - If data_valid_o is 0 or data_ready_i is 1 in that cycle: load data_o, set data_valid_o=1, pulse rx_done_o. Also pulse parity_err_o if the flag is latched; a parity-error byte is still delivered.
  - Otherwise: keep the old data_o, pulse overrun_o, no rx_done_o. A latched parity error also pulses parity_err_o.
- data_valid_o clears the cycle after valid & ready, unless a new byte is loaded in that same cycle.
- rx_en_i=0 in any non-IDLE state: return to IDLE next cycle with no pulses. The holding register is untouched.
- Latency: rx_done_o occurs 3 cycles after the tick of the final stop mid-sample (2 synchronizer cycles + 1 register). For 8N1 that is 9.5 bit times after the line edge plus 3 cycles.
- A new start edge is accepted from the IDLE cycle right after delivery, so back-to-back frames work at 1 stop bit.

Decomposition:
- uart_pkg additions:
  - typedef enum uart_rx_state_t (the 6 states).
  - localparam UART_OVERSAMPLE=16.
  - Encodings for data_bits.
- Event pulses map to the existing IRQ_RX_DONE, IRQ_UART_PARITY_ERR and IRQ_UART_BAD_FRAME indices. Overrun gets a new index.
- Sub-module uart_baud_tick (divider plus tick output, with a sync-reload input), shared with the future TX core.

Test Plan:
- Setup: OVERSAMPLE=16, baud_div=4 (64 clk/bit), 8N1, ready=1. Send 0xA5 -> data_o=0xA5, valid=1, one rx_done pulse at edge+608+3 cycles, no error pulses.
- 8E1, send 0x3C with parity bit 1 (wrong) -> data_o=0x3C delivered, parity_err_o and rx_done_o pulse in the same cycle. Same frame with parity bit 0 -> no parity_err.
- 8N1 frame 0x55 with stop bit 0, line held low for 20 bits -> bad_frame_o pulse, valid stays 0, rx_busy_o=1 until line high. Then 0x12 is received correctly.
- Low glitch of 24 clk (<32) in IDLE -> returns to IDLE, no pulses, data_valid_o stays 0.
- ready=0, send 0x11 then 0x22 -> data_o=0x11, valid=1, overrun_o pulse at the second frame end. Raise ready -> valid drops the next cycle.
- Assert rstn_i low mid-DATA of 0x7E -> all outputs 0 immediately. After release, 0x81 is received correctly; 7N2 with 0x81 -> data_o=0x01.
